// File: rtl/iiitb_elc_pkg.sv
// Shared types and one-hot floor helpers for the elevator request scheduler.
// The helpers work on floor_t, so override N_FLOORS_DEF and the top's N_FLOORS together.
package iiitb_elc_pkg;

    localparam int N_FLOORS_DEF = 8;

    typedef logic [N_FLOORS_DEF-1:0] floor_t;

    typedef enum logic [1:0] {
        IDLE,
        MOVING,
        ARRIVED
    } state_t;

    function automatic floor_t lowest_set(input floor_t v);
        return v & (~v + floor_t'(1));
    endfunction

    function automatic floor_t highest_set(input floor_t v);
        floor_t r;
        r = '0;
        for (int i = 0; i < N_FLOORS_DEF; i++) begin
            if (v[i]) r = floor_t'(1) << i;
        end
        return r;
    endfunction

    function automatic logic is_onehot(input floor_t v);
        return (v != '0) && ((v & (v - floor_t'(1))) == '0);
    endfunction

    // Bits strictly above a one-hot floor; the shift drops out naturally at the top floor.
    function automatic floor_t above_mask(input floor_t cur);
        return ~((cur << 1) - floor_t'(1));
    endfunction

    function automatic floor_t below_mask(input floor_t cur);
        return cur - floor_t'(1);
    endfunction

endpackage

// File: rtl/iiitb_elc_target_sel.sv
// Combinational SCAN selector: serve the current floor first, then continue the sweep,
// reversing direction only when nothing is left ahead.
module iiitb_elc_target_sel
    import iiitb_elc_pkg::*;
(
    input  floor_t pending,
    input  floor_t current_floor,
    input  logic   sweep_up,
    output floor_t target,
    output logic   next_sweep_up
);

    floor_t above;
    floor_t below;
    floor_t here;

    assign above = pending & above_mask(current_floor);
    assign below = pending & below_mask(current_floor);
    assign here  = pending & current_floor;

    always_comb begin
        target        = current_floor;
        next_sweep_up = sweep_up;
        if (here == '0) begin
            if (sweep_up) begin
                if (above != '0) begin
                    target = lowest_set(above);
                end else begin
                    target        = highest_set(below);
                    next_sweep_up = 1'b0;
                end
            end else begin
                if (below != '0) begin
                    target = highest_set(below);
                end else begin
                    target        = lowest_set(above);
                    next_sweep_up = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/iiitb_elc_req_sched.sv
// Request scheduler in front of the elevator controller: latches calls, picks the next
// floor by SCAN, retargets to calls passed en route and times the door dwell.
module iiitb_elc_req_sched
    import iiitb_elc_pkg::*;
#(
    parameter int N_FLOORS     = N_FLOORS_DEF,
    parameter int DWELL_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_FLOORS-1:0] floor_call,
    input  logic [N_FLOORS-1:0] current_floor,
    input  logic                complete,
    input  logic                over_time,
    input  logic                over_weight,
    output logic [N_FLOORS-1:0] request_floor,
    output logic [N_FLOORS-1:0] pending,
    output logic                busy,
    output logic                door_open,
    output logic                served,
    output logic                sweep_up,
    output logic                floor_err
);

    localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL_CYCLES - 1);

    state_t        state_reg;
    floor_t        pending_reg;
    floor_t        request_reg;
    logic          sweep_reg;
    logic          door_reg;
    logic          served_reg;
    logic          busy_reg;
    logic          ferr_reg;
    logic [CW-1:0] dwell_reg;

    floor_t sel_target;
    logic   sel_sweep;
    floor_t enroute;
    floor_t pickup;
    floor_t clear_mask;
    floor_t call_mask;
    floor_t pending_next;
    logic   alert;
    logic   floor_bad;
    logic   closing;
    logic   do_sel;
    logic   sel_arrive;
    logic   mov_arrive;

    iiitb_elc_target_sel u_sel (
        .pending       (pending_reg),
        .current_floor (current_floor),
        .sweep_up      (sweep_reg),
        .target        (sel_target),
        .next_sweep_up (sel_sweep)
    );

    always_comb begin
        alert      = over_time | over_weight;
        floor_bad  = !is_onehot(current_floor);
        closing    = (state_reg == ARRIVED) && (dwell_reg == '0) && !alert;
        // Door closing with work left re-selects on the same edge, so no idle cycle.
        do_sel     = ((state_reg == IDLE) || closing) && !floor_bad && (pending_reg != '0);
        sel_arrive = do_sel && (sel_target == current_floor);
        mov_arrive = (state_reg == MOVING) && !floor_bad && complete
                     && (current_floor == request_reg);
        if (sweep_reg)
            enroute = pending_reg & above_mask(current_floor) & below_mask(request_reg);
        else
            enroute = pending_reg & below_mask(current_floor) & above_mask(request_reg);
        pickup       = sweep_reg ? lowest_set(enroute) : highest_set(enroute);
        clear_mask   = sel_arrive ? sel_target : (mov_arrive ? request_reg : '0);
        call_mask    = door_reg ? ~request_reg : '1;
        pending_next = (pending_reg | (floor_call & call_mask)) & ~clear_mask;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            pending_reg <= '0;
            request_reg <= floor_t'(1);
            sweep_reg   <= 1'b1;
            door_reg    <= 1'b0;
            served_reg  <= 1'b0;
            busy_reg    <= 1'b0;
            ferr_reg    <= 1'b0;
            dwell_reg   <= '0;
        end else begin
            pending_reg <= pending_next;
            ferr_reg    <= floor_bad;
            served_reg  <= 1'b0;
            if (do_sel) begin
                request_reg <= sel_target;
                sweep_reg   <= sel_sweep;
            end
            if (sel_arrive || mov_arrive) begin
                state_reg  <= ARRIVED;
                busy_reg   <= 1'b1;
                served_reg <= 1'b1;
                door_reg   <= 1'b1;
                dwell_reg  <= DWELL_LOAD;
            end else if (do_sel) begin
                state_reg <= MOVING;
                busy_reg  <= 1'b1;
                door_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    MOVING: begin
                        if (floor_bad) begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                        end else if (enroute != '0) begin
                            request_reg <= pickup;
                        end
                    end
                    ARRIVED: begin
                        if (alert) begin
                            dwell_reg <= DWELL_LOAD;
                        end else if (dwell_reg == '0) begin
                            door_reg  <= 1'b0;
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                        end else begin
                            dwell_reg <= dwell_reg - CW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign request_floor = request_reg;
    assign pending       = pending_reg;
    assign busy          = busy_reg;
    assign door_open     = door_reg;
    assign served        = served_reg;
    assign sweep_up      = sweep_reg;
    assign floor_err     = ferr_reg;

endmodule

// File: tb/tb_iiitb_elc_req_sched.sv
// Directed bench for the request scheduler; served floors are scoreboarded by a monitor.
module tb_iiitb_elc_req_sched;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] floor_call = 8'h00;
    logic [7:0] current_floor = 8'h01;
    logic       complete = 1'b0;
    logic       over_time = 1'b0;
    logic       over_weight = 1'b0;
    logic [7:0] request_floor;
    logic [7:0] pending;
    logic       busy;
    logic       door_open;
    logic       served;
    logic       sweep_up;
    logic       floor_err;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] floor;
        logic       sweep;
        int         dwell;
    } exp_t;

    exp_t exp_q[$];

    iiitb_elc_req_sched #(.N_FLOORS(8), .DWELL_CYCLES(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .floor_call    (floor_call),
        .current_floor (current_floor),
        .complete      (complete),
        .over_time     (over_time),
        .over_weight   (over_weight),
        .request_floor (request_floor),
        .pending       (pending),
        .busy          (busy),
        .door_open     (door_open),
        .served        (served),
        .sweep_up      (sweep_up),
        .floor_err     (floor_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic push(input logic [7:0] f, input logic s, input int d);
        exp_t e;
        e.floor = f;
        e.sweep = s;
        e.dwell = d;
        exp_q.push_back(e);
    endtask

    task automatic call(input logic [7:0] f);
        floor_call = f;
        @(negedge clk);
        floor_call = 8'h00;
        @(negedge clk);
    endtask

    // Plant model: one floor per cycle toward request_floor, complete on arrival.
    task automatic run_car(input logic [7:0] inject_at, input logic [7:0] inject_call);
        int  n;
        logic got;
        got = 1'b0;
        for (n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            floor_call = 8'h00;
            if (served) begin
                got = 1'b1;
            end else begin
                if (current_floor != request_floor)
                    current_floor = (request_floor > current_floor) ? current_floor << 1
                                                                    : current_floor >> 1;
                complete = (current_floor == request_floor);
                if (inject_call != 8'h00 && current_floor == inject_at)
                    floor_call = inject_call;
            end
        end
        complete = 1'b0;
        if (!got) begin
            n_vec++;
            n_bad++;
            $display("FAIL run_car: no served pulse within 40 cycles, request %h", request_floor);
        end
    endtask

    task automatic wait_door_closed();
        int n;
        for (n = 0; n < 60 && door_open; n++) @(negedge clk);
        if (door_open) begin
            n_vec++;
            n_bad++;
            $display("FAIL door_close_timeout: door_open still 1, expected 0");
        end
    endtask

    task automatic wait_idle();
        int n;
        for (n = 0; n < 60 && (busy || door_open); n++) @(negedge clk);
        check("idle_busy", {7'b0, busy}, 8'h00);
        check("idle_door", {7'b0, door_open}, 8'h00);
    endtask

    initial begin : monitor
        exp_t e;
        int   cnt;
        forever begin
            @(negedge clk);
            if (reset && served) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL sb_unexpected: served floor %h, none expected", request_floor);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_floor", request_floor, e.floor);
                    check("sb_sweep", {7'b0, sweep_up}, {7'b0, e.sweep});
                    cnt = 0;
                    while (door_open && cnt < 200) begin
                        cnt++;
                        @(negedge clk);
                    end
                    check("sb_dwell", 8'(cnt), 8'(e.dwell));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        repeat (2) @(negedge clk);
        check("in_reset_request", request_floor, 8'h01);
        check("in_reset_busy", {7'b0, busy}, 8'h00);
        reset = 1'b1;
        @(negedge clk);
        check("rst_request", request_floor, 8'h01);
        check("rst_pending", pending, 8'h00);
        check("rst_busy", {7'b0, busy}, 8'h00);
        check("rst_door", {7'b0, door_open}, 8'h00);
        check("rst_sweep", {7'b0, sweep_up}, 8'h01);
        check("rst_served", {7'b0, served}, 8'h00);
        check("rst_ferr", {7'b0, floor_err}, 8'h00);

        // Single call: pending one edge later, request one edge after that.
        push(8'h10, 1'b1, 4);
        floor_call = 8'h10;
        @(negedge clk);
        floor_call = 8'h00;
        check("t1_pending", pending, 8'h10);
        check("t1_request_hold", request_floor, 8'h01);
        check("t1_busy_early", {7'b0, busy}, 8'h00);
        @(negedge clk);
        check("t1_request", request_floor, 8'h10);
        check("t1_busy", {7'b0, busy}, 8'h01);
        run_car(8'h00, 8'h00);
        check("t1_pending_clr", pending, 8'h00);
        wait_idle();

        // SCAN: multi-hot call, top first, then reverse with no idle cycle.
        current_floor = 8'h04;
        push(8'h80, 1'b1, 4);
        push(8'h01, 1'b0, 4);
        call(8'h81);
        check("t2_pending", pending, 8'h81);
        check("t2_request", request_floor, 8'h80);
        run_car(8'h00, 8'h00);
        wait_door_closed();
        check("t2_request_rev", request_floor, 8'h01);
        check("t2_sweep_rev", {7'b0, sweep_up}, 8'h00);
        check("t2_busy_noidle", {7'b0, busy}, 8'h01);
        run_car(8'h00, 8'h00);
        wait_idle();

        // En-route pick-up: call for 0x08 while passing 0x02 toward 0x40.
        push(8'h08, 1'b1, 4);
        push(8'h40, 1'b1, 4);
        call(8'h40);
        check("t3_request", request_floor, 8'h40);
        check("t3_sweep", {7'b0, sweep_up}, 8'h01);
        run_car(8'h02, 8'h08);
        check("t3_pending_left", pending, 8'h40);
        check("t3_request_pick", request_floor, 8'h08);
        wait_door_closed();
        check("t3_request_next", request_floor, 8'h40);
        run_car(8'h00, 8'h00);
        wait_idle();

        // Alerts hold the door: 10 cycles held, then the full dwell after release.
        push(8'h20, 1'b0, 14);
        call(8'h20);
        run_car(8'h00, 8'h00);
        over_weight = 1'b1;
        repeat (10) @(negedge clk);
        check("t4_door_held_ow", {7'b0, door_open}, 8'h01);
        over_weight = 1'b0;
        wait_idle();

        push(8'h40, 1'b1, 14);
        call(8'h40);
        run_car(8'h00, 8'h00);
        over_time = 1'b1;
        repeat (10) @(negedge clk);
        check("t4_door_held_ot", {7'b0, door_open}, 8'h01);
        over_time = 1'b0;
        wait_idle();

        // Invalid floor feedback freezes selection with the call kept pending.
        current_floor = 8'h00;
        @(negedge clk);
        check("t5_ferr_zero", {7'b0, floor_err}, 8'h01);
        call(8'h20);
        check("t5_pending", pending, 8'h20);
        check("t5_request_hold", request_floor, 8'h40);
        check("t5_busy", {7'b0, busy}, 8'h00);
        current_floor = 8'h12;
        @(negedge clk);
        check("t5_ferr_multi", {7'b0, floor_err}, 8'h01);
        check("t5_request_hold2", request_floor, 8'h40);
        current_floor = 8'h40;
        @(negedge clk);
        check("t5_ferr_clear", {7'b0, floor_err}, 8'h00);
        check("t5_request", request_floor, 8'h20);
        check("t5_sweep", {7'b0, sweep_up}, 8'h00);
        check("t5_busy_move", {7'b0, busy}, 8'h01);

        // Asynchronous reset mid-move, checked between clock edges.
        #2;
        reset = 1'b0;
        #1;
        check("t6_request", request_floor, 8'h01);
        check("t6_pending", pending, 8'h00);
        check("t6_busy", {7'b0, busy}, 8'h00);
        check("t6_sweep", {7'b0, sweep_up}, 8'h01);
        check("t6_door", {7'b0, door_open}, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        current_floor = 8'h01;
        repeat (3) @(negedge clk);
        check("t6_stay_idle", {7'b0, busy}, 8'h00);
        check("sb_empty", 8'(exp_q.size()), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/iiitb_elc_req_sched.md
Name: iiitb_elc_req_sched

Overview:
- Request scheduler directly upstream of the elevator controller.
- Latches car/hall calls into a pending-floor register and chooses the next target with a SCAN (sweep) policy.
- Drives the controller's one-hot request_floor, watches its complete/out_current_floor feedback, and times the door dwell at each served floor.

Parameters:
- N_FLOORS, 8, number of floors; width of all one-hot floor vectors.
- DWELL_CYCLES, 4, clk cycles door_open stays high at a served floor (minimum 1).

Ports:
- clk  in  1  low-frequency system clock, rising edge.
- reset  in  1  asynchronous, active-low; all state cleared while 0.
- floor_call  in  N_FLOORS  car/hall buttons; any set bit is a call for that floor; may be multi-hot.
- current_floor  in  N_FLOORS  controller's out_current_floor, expected one-hot.
- complete  in  1  controller complete.
- over_time  in  1  door held too long (shared with controller).
- over_weight  in  1  overload (shared with controller).
- request_floor  out  N_FLOORS  one-hot target to controller.
- pending  out  N_FLOORS  outstanding calls.
- busy  out  1  state != IDLE.
- door_open  out  1  door dwell active.
- served  out  1  one-cycle pulse when a floor is served.
- sweep_up  out  1  current scan direction (1 = up).
- floor_err  out  1  current_floor not exactly one-hot.

Behaviour:
- Reset (async, reset=0) values: state=IDLE, pending=0, request_floor=1 (floor 0), sweep_up=1, door_open=0, served=0, busy=0, floor_err=0, dwell counter=0. Reset mid-move drops all pending calls.
- All outputs are registered.
- pending update each edge: pending <= (pending | floor_call) & ~clear_mask. clear_mask is the served floor's bit on the ARRIVED entry edge, else 0.
  - A call for the floor currently being served with door_open=1 is ignored.
  - A call for an already-pending floor is a no-op.
- Selection function (combinational, package function):
  - above = pending bits strictly above current_floor; below = bits strictly below; here = pending & current_floor.
  - If here != 0: target = current_floor.
  - Else if sweep_up=1: lowest bit of above; if above=0, highest bit of below and flip sweep_up to 0.
  - Else (sweep_up=0): highest bit of below; if below=0, lowest bit of above and flip sweep_up to 1.
- FSM states:
  - IDLE
    - If floor_err: stay; request_floor holds.
    - If pending != 0: register target into request_floor.
    - Go to ARRIVED if target == current_floor, else MOVING.
    - Latency: a call pulse sampled at edge N appears in pending at N+1; request_floor updates at N+2.
  - MOVING
    - request_floor is held, except: a pending bit lying strictly between current_floor and request_floor in the sweep direction retargets request_floor to that nearer floor (pick-up en route).
    - complete=1 and current_floor==request_floor: go to ARRIVED.
    - floor_err: go to IDLE with pending retained.
    - over_time or over_weight: stay in MOVING (controller freezes itself).
  - ARRIVED
    - Entry edge: served=1 for one cycle, clear the bit, door_open=1, counter=DWELL_CYCLES-1.
    - Counter decrements each cycle. If over_time or over_weight is 1, the counter reloads to DWELL_CYCLES-1 (door stays open indefinitely).
    - Counter==0 with both alerts low: door_open=0. Go to IDLE if pending==0, else re-select as in IDLE (next edge).
- Boundaries:
  - Top floor reached with sweep_up=1 and only lower calls: direction flips, no idle cycle.
  - Floor 0 symmetric.
  - Multi-hot floor_call latches all bits in one cycle.
  - floor_err = registered (current_floor==0 or more than one bit set).

Decomposition:
- Package iiitb_elc_pkg:
  - state enum {IDLE, MOVING, ARRIVED}
  - N_FLOORS default
  - functions lowest_set, highest_set, is_onehot, above_mask, below_mask
- One sub-module: iiitb_elc_target_sel (combinational SCAN selector: pending, current_floor, sweep_up -> target, next_sweep_up). Top holds the FSM, pending register and dwell counter.

Test Plan:
- Reset: release reset with current_floor=8'h01 -> request_floor=8'h01, pending=0, busy=0, door_open=0.
- Single call: floor_call=8'h10 one cycle at edge N, current_floor=8'h01 -> pending=8'h10 at N+1, request_floor=8'h10 and busy=1 at N+2. Model steps floors up to 8'h10 with complete=1 -> served pulse, pending=0, door_open high exactly 4 cycles, then IDLE.
- SCAN order: current 8'h04, sweep_up=1, calls 8'h81 -> request 8'h80 first. After serving: sweep_up=0, request 8'h01.
- En-route pick-up: moving 8'h01->8'h40, call 8'h08 while current=8'h02 -> request_floor becomes 8'h08; 8'h40 stays pending and is served next.
- Alerts: over_weight=1 during ARRIVED for 10 cycles -> door_open stays 1, then 4 more cycles after release. Same with over_time.
- Faults: current_floor=8'h00 or 8'h12 in IDLE with pending=8'h20 -> floor_err=1, request_floor unchanged. Async reset pulse in MOVING -> all outputs to reset values immediately, without waiting for a clock edge.
